serial_nibble_adder_ctrl: RTL and testbench
===========================================

SERIAL_NIBBLE_ADDER_CTRL -- requirements
Module: serial_nibble_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b, cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in to the LSB nibble.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result a + b + cin, modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 The block SHALL compute all arithmetic through exactly one instance of the team's 4-bit ripple_carry_adder.
- The block SHALL NOT contain any other adder.
REQ-015 The block SHALL implement an FSM with three states: IDLE, ADD and DONE.
REQ-016 in_ready SHALL be 1 exactly when state = IDLE, including while rst_n is low.
REQ-017 out_valid SHALL be 1 exactly when state = DONE.
REQ-018 Accept SHALL be defined as in_valid & in_ready at a rising edge.
- On accept, the block SHALL latch a and b into internal shift registers.
- On accept, the carry register SHALL be set to cin.
- On accept, the nibble counter SHALL be set to 0.
- On accept, the state SHALL go to ADD.
REQ-019 On each ADD cycle, the adder inputs SHALL be the low nibbles of the A and B shift registers and the carry register.
- The A and B shift registers SHALL shift right by 4.
- The adder sum nibble SHALL shift into the top of the result register.
- The carry register SHALL take the adder carry-out.
- The counter SHALL increment by 1.
REQ-020 ADD SHALL last exactly WIDTH/4 cycles, after which the state SHALL go to DONE.
- out_valid SHALL rise WIDTH/4 edges after the accept edge, i.e. 4 edges when WIDTH = 16.
REQ-021 On the final ADD cycle, ovf SHALL be registered as 1 iff the MSBs of a and b are equal and the MSB of the result differs from them.
REQ-022 In DONE, the block SHALL hold sum, cout and ovf stable until out_valid & out_ready.
- On out_valid & out_ready, the state SHALL return to IDLE at that edge.
REQ-023 The block SHALL NOT overlap transactions.
- in_valid SHALL be ignored in ADD and DONE.
- The earliest next accept SHALL be the edge after the result handshake.
REQ-024 sum, cout and ovf SHALL keep their last result values in IDLE until overwritten.
- They SHALL update only at the transition from ADD to DONE.
- The partial result register SHALL be internal; sum SHALL NOT expose partial nibbles.
REQ-025 Changes on a, b or cin after the accept edge SHALL NOT affect the result.
REQ-026 When cin = 1 and the operands wrap, the result SHALL wrap modulo 2^WIDTH with cout = 1.
- Example: all-ones + 0 + cin 1 gives sum 0 and cout 1.

Reset
REQ-027 While rst_n is low, the outputs SHALL be:
- state = IDLE
- in_ready = 1
- out_valid = 0
- sum = 0
- cout = 0
- ovf = 0
- Internal shift registers, carry register and counter SHALL all be 0.
REQ-028 Reset assertion in ADD or DONE SHALL abort the transaction immediately and asynchronously; no result SHALL be presented.
REQ-029 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-030 The bench SHALL cover the basic add with WIDTH = 16.
- Stimulus: a = 0x1234, b = 0x4321, cin = 0.
- Required response: sum = 0x5555, cout = 0, ovf = 0.
- out_valid SHALL rise exactly 4 edges after the accept edge.
REQ-031 The bench SHALL cover unsigned wrap.
- Stimulus: a = 0xFFFF, b = 0x0001, cin = 0.
- Required response: sum = 0x0000, cout = 1, ovf = 0.
REQ-032 The bench SHALL cover signed overflow.
- Stimulus: a = 0x7FFF, b = 0x0001, cin = 0.
- Required response: sum = 0x8000, cout = 0, ovf = 1.
- Stimulus: a = 0x8000, b = 0x8000, cin = 0.
- Required response: sum = 0x0000, cout = 1, ovf = 1.
REQ-033 The bench SHALL cover carry-in and backpressure.
- Stimulus: a = 0x000F, b = 0x0000, cin = 1, then out_ready held low for 5 cycles with in_valid held high.
- Required response: sum = 0x0010 held stable, in_ready = 0 throughout.
- The second accept SHALL occur only on the edge after out_ready rises.
REQ-034 The bench SHALL cover reset mid-operation.
- Stimulus: assert rst_n low after 2 ADD cycles.
- Required response: out_valid = 0 and sum = 0 immediately; in_ready = 1.
- A following transaction with a = 0x00FF, b = 0x0001, cin = 0 SHALL produce sum = 0x0100.
REQ-035 The bench SHALL cover back-to-back throughput.
- Stimulus: in_valid and out_ready held high continuously.
- Required response: one result every WIDTH/4 + 2 cycles.

Source files
------------

// File: rtl/serial_nibble_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_nibble_adder_ctrl
//
// Purpose: adds two WIDTH-bit operands plus a carry-in one nibble per clock.
// A single 4-bit ripple-carry adder is reused for every nibble, LSB first.
// The carry is kept in a register between nibbles. Signed overflow is taken
// on the last nibble. The result is held in output registers until the
// consumer takes it.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   valid must not depend on ready. A producer that raises valid may keep it
//   high until the transfer. in_ready is 1 only in IDLE, so in_valid is ignored
//   while a transaction is in flight. out_valid is 1 only in DONE. sum, cout and
//   ovf do not change until the result is taken.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b, cin valid
//   in_ready   out  block can accept operands (state == IDLE)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into the least-significant nibble
//   out_valid  out  result valid (state == DONE)
//   out_ready  in   consumer accepts the result
//   sum        out  a + b + cin modulo 2^WIDTH
//   cout       out  carry out of the MSB
//   ovf        out  two's-complement signed overflow
//   dbg_state  out  FSM state: 0 = IDLE, 1 = ADD, 2 = DONE
//
// WIDTH must be a multiple of 4 and at least 8.
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder: the only arithmetic element in this block.
module ripple_carry_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[4];
endmodule

module serial_nibble_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [3:0]         w_nib_sum;
  logic               w_nib_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  ripple_carry_adder u_rca (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  assign w_last = (r_cnt == CNT_W'(NIB - 1));

  // The current nibble enters at the top. After NIB shifts the LSB nibble
  // has reached bit 0.
  assign w_res_next = {w_nib_sum, r_res[WIDTH-1:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is 1 in IDLE, so in_valid alone means accept.
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_state    <= S_ADD;
            r_in_ready <= 1'b0;
          end
        end

        S_ADD: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_res   <= w_res_next;
          r_carry <= w_nib_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_sum       <= w_res_next;
            r_cout      <= w_nib_cout;
            // On the last nibble, r_a[3] and r_b[3] hold the operand MSBs and
            // w_nib_sum[3] is the result MSB.
            r_ovf       <= (r_a[3] == r_b[3]) && (w_nib_sum[3] != r_a[3]);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_nibble_adder_ctrl
//
// Testbench for serial_nibble_adder_ctrl with WIDTH = 16. Tasks drive the
// inputs from initial blocks. Each accepted operand set pushes its expected
// {cout, ovf, sum} into exp_q. A monitor running on the falling edge pops and
// compares the queue on every result handshake. The monitor also checks
// result latency and that sum is held between results.
// -----------------------------------------------------------------------------
module tb_serial_nibble_adder_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int RW  = W + 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  serial_nibble_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [RW-1:0] exp_q[$];
  int          hs_q[$];
  int          last_accept = 0;
  int          last_hs = 0;
  logic        prev_ov = 1'b0;
  logic [RW-1:0] held_res = '0;
  bit          bp_on = 1'b0;

  // Reference model: plain wide addition. Signed overflow means the operands
  // share a sign and the result does not.
  function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!rst_n) begin
      prev_ov  = 1'b0;
      held_res = '0;
    end else begin
      if (!out_valid)
        chk("held_result", 64'({cout, ovf, sum}), 64'(held_res));
      if (out_valid && !prev_ov)
        chk("latency", 64'(cyc - last_accept), 64'(NIB));
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc + 1);
        last_hs = cyc + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h expected no result at cycle %0d",
                   {cout, ovf, sum}, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({cout, ovf, sum}), 64'(e));
          held_res = e;
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one operand set and waits for its accept edge. After the accept,
  // the operands are scrambled. in_valid stays at 'keep' so that late input
  // changes and held-high in_valid can be seen to have no effect.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic keep);
    int n;
    bit done;
    @(posedge clk);
    #1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(x, y, c));
        last_accept = cyc + 1;
        @(posedge clk);
        #1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        in_valid = keep;
        done = 1'b1;
      end
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [W-1:0] x;
    logic [W-1:0] y;

    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({cout, ovf, sum}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases with fixed expected values.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_drain();
    chk("basic", 64'({cout, ovf, sum}), 64'({1'b0, 1'b0, 16'h5555}));

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();
    chk("unsigned_wrap", 64'({cout, ovf, sum}), 64'({1'b1, 1'b0, 16'h0000}));

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();
    chk("pos_overflow", 64'({cout, ovf, sum}), 64'({1'b0, 1'b1, 16'h8000}));

    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_drain();
    chk("neg_overflow", 64'({cout, ovf, sum}), 64'({1'b1, 1'b1, 16'h0000}));

    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_drain();
    chk("cin_wrap", 64'({cout, ovf, sum}), 64'({1'b1, 1'b0, 16'h0000}));

    // Backpressure: hold out_ready low with in_valid held high.
    out_ready = 1'b0;
    send(16'h000F, 16'h0000, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum", 64'(sum), 64'h0010);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h0102, 16'h0304, 1'b0, 1'b0);
    chk("bp_second_accept", 64'(last_accept), 64'(last_hs + 1));
    wait_drain();
    chk("bp_second", 64'(sum), 64'h0406);

    // Reset after two ADD cycles.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(16'h00FF, 16'h0001, 1'b0));
    last_accept = cyc + 1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("first_edge_accept", 64'(dbg_state), 64'd1);
    wait_drain();
    chk("after_reset", 64'(sum), 64'h0100);

    // Randomized traffic with random consumer stalls.
    bp_on = 1'b1;
    fork
      begin
        repeat (25) begin
          x = pick();
          y = pick();
          send(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Back-to-back throughput.
    out_ready = 1'b1;
    hs_q.delete();
    repeat (6) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    chk("tp_count", 64'(hs_q.size()), 64'd6);
    for (int i = 1; i < hs_q.size(); i++)
      chk("throughput", 64'(hs_q[i] - hs_q[i-1]), 64'(NIB + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300000 ns");
    $fatal(1, "timeout");
  end
endmodule
